alu_frame_sequencer: RTL and testbench

- Byte-stream front end for the combinational `alu`. It sits directly upstream of the ALU, feeding it, and directly downstream, consuming its result.
- Assembles a command frame (opcode byte, operand A, operand B) from an 8-bit valid/ready input stream and drives `alu` inputs from registers.
- Captures the ALU result one cycle after the frame completes, then streams it out as bytes with backpressure.
- Sits between the board UART/host byte link and the `alu` instance inside `alu_top`.

---
 rtl/alu_pkg.sv | 28 ++
 rtl/alu.sv | 36 +++
 rtl/alu_byte_shifter.sv | 52 +++++
 rtl/alu_top.sv | 54 +++++
 rtl/alu_frame_sequencer.sv | 206 ++++++++++++++++++++
 tb/tb_alu_frame_sequencer.sv | 467 ++++++++++++++++++++++++++++++++++++++++
 6 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU byte-stream front end and the ALU itself.
//   - ALUControl encodings driven on alu_ctrl / consumed by alu
//   - Sequencer state enumeration
//   - Reserved-bit mask for the opcode byte and a helper that applies it
package alu_pkg;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [7:0] OPCODE_RSVD_MASK = 8'hF8;

  typedef enum logic [2:0] {
    IDLE,
    GET_A,
    GET_B,
    EXEC,
    SEND
  } seq_state_t;

  // An opcode byte is legal only when every reserved bit is clear.
  function automatic logic opcode_ok(input logic [7:0] op_byte);
    return (op_byte & OPCODE_RSVD_MASK) == 8'h00;
  endfunction

endpackage

// File: rtl/alu.sv
// Combinational ALU.
// Ports:
//   a, b         operands
//   alu_control  operation select (ALU_* encodings from alu_pkg)
//   result       operation result; unused encodings produce zero
module alu
  import alu_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [2:0]        alu_control,
  output logic [DATA_W-1:0] result
);

  logic [DATA_W-1:0] diff;
  logic              lt;

  always_comb begin
    diff = a - b;
    // Signed less-than: with differing signs the negative operand is smaller;
    // with equal signs the subtraction cannot overflow, so its sign decides.
    lt = (a[DATA_W-1] != b[DATA_W-1]) ? a[DATA_W-1] : diff[DATA_W-1];
    result = '0;
    case (alu_control)
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_ADD: result = a + b;
      ALU_SUB: result = diff;
      ALU_SLT: result = DATA_W'(lt);
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/alu_byte_shifter.sv
// DATA_W-bit register that is either loaded in parallel or shifted left by
// one byte, the new byte entering at the least significant end. The most
// significant byte of the register is the one presented first when a word is
// streamed out, so the same block serves as operand assembler and result
// serializer.
// Ports:
//   clk, reset       clock, asynchronous active-low reset
//   load_en/load_data parallel load (has priority over shift)
//   shift_en/shift_in shift left by 8, shift_in enters at bits [7:0]
//   data             current register contents
module alu_byte_shifter #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_en,
  input  logic [DATA_W-1:0] load_data,
  input  logic              shift_en,
  input  logic [7:0]        shift_in,
  output logic [DATA_W-1:0] data
);

  logic [DATA_W-1:0] data_q;
  logic [DATA_W-1:0] data_d;

  // NOTE: every always_comb output gets a default on its first line, so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    data_d = data_q;
    if (load_en) begin
      data_d = load_data;
    end else if (shift_en) begin
      // Written as a shift rather than a part-select so DATA_W == 8 works.
      data_d = (data_q << 8) | DATA_W'(shift_in);
    end
  end

  // NOTE: this is a datapath register, yet it is reset because its contents
  // are visible on the ALU ports and must read zero straight out of reset.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  assign data = data_q;

endmodule

// File: rtl/alu_top.sv
// Byte-link ALU: frame sequencer wired to the combinational alu.
// Ports:
//   clk, reset                    clock, asynchronous active-low reset
//   in_data/in_valid/in_ready     command byte stream from the host link
//   out_data/out_valid/out_ready  result byte stream to the host link
//   busy, frame_err, frame_count  sequencer status
module alu_top #(
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 1000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [7:0]  out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        busy,
  output logic        frame_err,
  output logic [15:0] frame_count
);

  logic [DATA_W-1:0] alu_a;
  logic [DATA_W-1:0] alu_b;
  logic [2:0]        alu_ctrl;
  logic [DATA_W-1:0] alu_result;

  alu_frame_sequencer #(.DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) u_seq (
    .clk         (clk),
    .reset       (reset),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_ctrl    (alu_ctrl),
    .alu_result  (alu_result),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .busy        (busy),
    .frame_err   (frame_err),
    .frame_count (frame_count)
  );

  alu #(.DATA_W(DATA_W)) u_alu (
    .a           (alu_a),
    .b           (alu_b),
    .alu_control (alu_ctrl),
    .result      (alu_result)
  );

endmodule

// File: rtl/alu_frame_sequencer.sv
// Byte-stream front end for the combinational alu.
// Collects a frame {opcode, A (big-endian), B (big-endian)} from an 8-bit
// valid/ready stream, holds the ALU inputs in registers, captures the ALU
// result one cycle after the frame completes and streams it out MSB first.
// Ports:
//   clk, reset                    clock, asynchronous active-low reset
//   in_data/in_valid/in_ready     command byte stream (in_ready registered)
//   alu_a/alu_b/alu_ctrl          registered ALU inputs
//   alu_result                    combinational ALU result
//   out_data/out_valid/out_ready  result byte stream
//   busy                          state is not IDLE
//   frame_err                     one-cycle pulse: bad opcode or timeout
//   frame_count                   completed frames, wraps at 16 bits
module alu_frame_sequencer
  import alu_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 1000000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [2:0]        alu_ctrl,
  input  logic [DATA_W-1:0] alu_result,
  output logic [7:0]        out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              frame_err,
  output logic [15:0]       frame_count
);

  localparam int BYTES = DATA_W / 8;
  localparam int CNT_W = $clog2(BYTES + 1);
  localparam int TMO_W = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(BYTES - 1);
  // The abort happens on the edge where the idle count would reach
  // TIMEOUT-1, i.e. while the registered count still holds TIMEOUT-2.
  localparam logic [TMO_W-1:0] TMO_LIMIT = TMO_W'(TIMEOUT - 2);

  seq_state_t        state_q, state_d;
  logic              in_ready_q, in_ready_d;
  logic [2:0]        ctrl_q, ctrl_d;
  logic [CNT_W-1:0]  byte_cnt_q, byte_cnt_d;
  logic [TMO_W-1:0]  tmo_cnt_q, tmo_cnt_d;
  logic              out_valid_q, out_valid_d;
  logic              frame_err_q, frame_err_d;
  logic [15:0]       frame_count_q, frame_count_d;

  logic              in_acc;
  logic              out_acc;
  logic              a_shift;
  logic              b_shift;
  logic              r_load;
  logic              r_shift;
  logic [DATA_W-1:0] result_q;

  assign in_acc  = in_valid && in_ready_q;
  assign out_acc = out_valid_q && out_ready;

  always_comb begin
    state_d       = state_q;
    ctrl_d        = ctrl_q;
    byte_cnt_d    = byte_cnt_q;
    tmo_cnt_d     = tmo_cnt_q;
    out_valid_d   = out_valid_q;
    frame_err_d   = 1'b0;
    frame_count_d = frame_count_q;
    a_shift       = 1'b0;
    b_shift       = 1'b0;
    r_load        = 1'b0;
    r_shift       = 1'b0;

    case (state_q)
      IDLE: begin
        if (in_acc) begin
          if (opcode_ok(in_data)) begin
            ctrl_d     = in_data[2:0];
            byte_cnt_d = '0;
            tmo_cnt_d  = '0;
            state_d    = GET_A;
          end else begin
            // Bad opcode is swallowed; alu_ctrl keeps its old value.
            frame_err_d = 1'b1;
          end
        end
      end

      GET_A, GET_B: begin
        if (in_acc) begin
          a_shift   = (state_q == GET_A);
          b_shift   = (state_q == GET_B);
          tmo_cnt_d = '0;
          if (byte_cnt_q == LAST_BYTE) begin
            byte_cnt_d = '0;
            state_d    = (state_q == GET_A) ? GET_B : EXEC;
          end else begin
            byte_cnt_d = byte_cnt_q + 1'b1;
          end
        end else if (tmo_cnt_q == TMO_LIMIT) begin
          // Partial operands stay in their shifters; nothing is produced.
          frame_err_d = 1'b1;
          tmo_cnt_d   = '0;
          byte_cnt_d  = '0;
          state_d     = IDLE;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
      end

      EXEC: begin
        // ALU inputs have been stable for a full cycle; capture its result.
        r_load      = 1'b1;
        out_valid_d = 1'b1;
        byte_cnt_d  = '0;
        state_d     = SEND;
      end

      SEND: begin
        if (out_acc) begin
          r_shift = 1'b1;
          if (byte_cnt_q == LAST_BYTE) begin
            out_valid_d   = 1'b0;
            frame_count_d = frame_count_q + 16'd1;
            byte_cnt_d    = '0;
            state_d       = IDLE;
          end else begin
            byte_cnt_d = byte_cnt_q + 1'b1;
          end
        end
      end

      default: state_d = IDLE;
    endcase

    // in_ready is registered: it reflects whether the next state takes input.
    in_ready_d = (state_d == IDLE) || (state_d == GET_A) || (state_d == GET_B);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      in_ready_q    <= 1'b0;
      ctrl_q        <= 3'b000;
      byte_cnt_q    <= '0;
      tmo_cnt_q     <= '0;
      out_valid_q   <= 1'b0;
      frame_err_q   <= 1'b0;
      frame_count_q <= 16'd0;
    end else begin
      state_q       <= state_d;
      in_ready_q    <= in_ready_d;
      ctrl_q        <= ctrl_d;
      byte_cnt_q    <= byte_cnt_d;
      tmo_cnt_q     <= tmo_cnt_d;
      out_valid_q   <= out_valid_d;
      frame_err_q   <= frame_err_d;
      frame_count_q <= frame_count_d;
    end
  end

  alu_byte_shifter #(.DATA_W(DATA_W)) u_a_shifter (
    .clk       (clk),
    .reset     (reset),
    .load_en   (1'b0),
    .load_data ('0),
    .shift_en  (a_shift),
    .shift_in  (in_data),
    .data      (alu_a)
  );

  alu_byte_shifter #(.DATA_W(DATA_W)) u_b_shifter (
    .clk       (clk),
    .reset     (reset),
    .load_en   (1'b0),
    .load_data ('0),
    .shift_en  (b_shift),
    .shift_in  (in_data),
    .data      (alu_b)
  );

  // Result register: loaded at the end of EXEC, shifted one byte per
  // output handshake so its top byte is always the byte on out_data.
  alu_byte_shifter #(.DATA_W(DATA_W)) u_r_shifter (
    .clk       (clk),
    .reset     (reset),
    .load_en   (r_load),
    .load_data (alu_result),
    .shift_en  (r_shift),
    .shift_in  (8'h00),
    .data      (result_q)
  );

  assign in_ready    = in_ready_q;
  assign alu_ctrl    = ctrl_q;
  assign out_data    = result_q[DATA_W-1 -: 8];
  assign out_valid   = out_valid_q;
  assign busy        = (state_q != IDLE);
  assign frame_err   = frame_err_q;
  assign frame_count = frame_count_q;

endmodule

// File: tb/tb_alu_frame_sequencer.sv
// Self-checking bench for alu_frame_sequencer driving a real alu instance.
// Inputs are driven on the falling edge and outputs sampled there too, so
// every handshake that the next rising edge will perform is known in advance.
module tb_alu_frame_sequencer;

  localparam int DATA_W  = 32;
  localparam int TIMEOUT = 16;
  localparam int FRAME   = 9;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [2:0]  alu_ctrl;
  logic [31:0] alu_result;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic        busy;
  logic        frame_err;
  logic [15:0] frame_count;

  always #5 clk = ~clk;

  alu_frame_sequencer #(.DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
    .clk         (clk),
    .reset       (reset),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_ctrl    (alu_ctrl),
    .alu_result  (alu_result),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .busy        (busy),
    .frame_err   (frame_err),
    .frame_count (frame_count)
  );

  alu #(.DATA_W(DATA_W)) u_alu (
    .a           (alu_a),
    .b           (alu_b),
    .alu_control (alu_ctrl),
    .result      (alu_result)
  );

  int checks   = 0;
  int failures = 0;

  int cyc          = 0;   // rising edges since the last reset release
  int last_in_edge = -1;  // edge that consumed the most recent input byte
  int first_ov_cyc = -1;  // first edge after which out_valid was seen high
  int exec_edge    = -1;
  int err_count    = 0;
  int err_cyc      = -1;
  int acc_count    = 0;
  int iready_bad   = 0;
  logic [2:0] ctrl_at_err;

  logic [7:0]  tx_q[$];
  logic [7:0]  rx_q[$];
  logic [31:0] exp_q[$];

  // Reference ALU straight from the operation definitions.
  function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    case (op)
      3'b000:  return a & b;
      3'b001:  return a | b;
      3'b010:  return a + b;
      3'b110:  return a - b;
      3'b111:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 7))
      0:       return 32'h0000_0000;
      1:       return 32'h7FFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  task automatic push_frame(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    tx_q.push_back({5'b00000, op});
    for (int i = 3; i >= 0; i--) tx_q.push_back(a[i*8 +: 8]);
    for (int i = 3; i >= 0; i--) tx_q.push_back(b[i*8 +: 8]);
    exp_q.push_back(model(op, a, b));
  endtask

  // Drive one cycle's inputs, advance to the next falling edge, then monitor.
  task automatic cycle(input logic iv, input logic [7:0] id, input logic ordy);
    in_valid  = iv;
    in_data   = id;
    out_ready = ordy;
    @(negedge clk);
    cyc++;
    if (frame_err === 1'b1) begin
      err_count++;
      err_cyc     = cyc;
      ctrl_at_err = alu_ctrl;
    end
    if (out_valid === 1'b1 && in_ready === 1'b1) iready_bad++;
  endtask

  // Send everything in tx_q and collect want_rx output bytes. out_ready is
  // held low for the first `stall` cycles with out_valid high, then is either
  // constantly high or toggles every cycle.
  task automatic stream(input int stall, input bit toggle, input int want_rx,
                        input bit exec_chk, input int budget);
    int         target;
    int         stalled;
    int         n;
    bit         phase;
    bit         holding;
    logic [7:0] held;
    logic       iv;
    logic       ordy;
    logic [7:0] id;
    target       = rx_q.size() + want_rx;
    stalled      = 0;
    n            = 0;
    phase        = 1'b0;
    holding      = 1'b0;
    held         = 8'h00;
    first_ov_cyc = -1;
    while (tx_q.size() > 0 || rx_q.size() < target) begin
      if (n >= budget) begin
        checks++;
        failures++;
        $display("FAIL stream_budget: gave up after %0d cycles, tx_left=%0d rx=%0d required_rx=%0d",
                 n, tx_q.size(), rx_q.size(), target);
        break;
      end
      n++;
      if (out_valid === 1'b1 && first_ov_cyc < 0) first_ov_cyc = cyc;
      if (holding && out_valid === 1'b1) begin
        checks++;
        if (out_data !== held) begin
          failures++;
          $display("FAIL stall_stable: out_data=%02h required=%02h at cycle %0d", out_data, held, cyc);
        end
      end
      iv = (tx_q.size() > 0);
      id = iv ? tx_q[0] : 8'h00;
      if (out_valid === 1'b1 && stalled < stall) begin
        ordy = 1'b0;
        stalled++;
      end else if (toggle) begin
        ordy  = phase;
        phase = ~phase;
      end else begin
        ordy = 1'b1;
      end
      holding = (out_valid === 1'b1) && !ordy;
      held    = out_data;
      if (iv && in_ready === 1'b1) begin
        void'(tx_q.pop_front());
        acc_count++;
        last_in_edge = cyc + 1;
        if (exec_chk && (acc_count % FRAME) == 0) exec_edge = cyc + 1;
      end
      if (out_valid === 1'b1 && ordy) rx_q.push_back(out_data);
      cycle(iv, id, ordy);
      if (exec_chk && cyc == exec_edge) begin
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
          failures++;
          $display("FAIL exec_cycle: in_ready=%b out_valid=%b required 0/0 at cycle %0d",
                   in_ready, out_valid, cyc);
        end
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({in_ready, out_valid, busy, frame_err} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_flags: in_ready/out_valid/busy/frame_err=%b required 0000",
               {in_ready, out_valid, busy, frame_err});
    end
    checks++;
    if (alu_a !== 32'd0 || alu_b !== 32'd0 || alu_ctrl !== 3'd0) begin
      failures++;
      $display("FAIL reset_alu_inputs: a=%08h b=%08h ctrl=%0d required 0/0/0", alu_a, alu_b, alu_ctrl);
    end
    checks++;
    if (out_data !== 8'h00 || frame_count !== 16'd0) begin
      failures++;
      $display("FAIL reset_out: out_data=%02h frame_count=%0d required 00/0", out_data, frame_count);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      failures++;
      $display("FAIL reset_release_ready: in_ready=%b required 0 before first edge", in_ready);
    end
    @(negedge clk);
    cyc = 0;
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL ready_after_reset: in_ready=%b busy=%b required 1/0", in_ready, busy);
    end
  endtask

  task automatic test_add();
    rx_q.delete();
    exp_q.delete();
    push_frame(3'b010, 32'd5, 32'd3);
    stream(0, 1'b0, 4, 1'b0, 200);
    checks++;
    if (rx_q.size() != 4 || {rx_q[0], rx_q[1], rx_q[2], rx_q[3]} !== 32'h0000_0008) begin
      failures++;
      $display("FAIL add_result: got %0d bytes, required 00000008", rx_q.size());
    end
    checks++;
    if (first_ov_cyc != last_in_edge + 1) begin
      failures++;
      $display("FAIL add_latency: out_valid first after edge %0d, required edge %0d",
               first_ov_cyc, last_in_edge + 1);
    end
    checks++;
    if (frame_count !== 16'd1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL add_count: frame_count=%0d busy=%b required 1/0", frame_count, busy);
    end
    checks++;
    if (alu_a !== 32'd5 || alu_b !== 32'd3 || alu_ctrl !== 3'b010) begin
      failures++;
      $display("FAIL add_hold: a=%08h b=%08h ctrl=%0d required 5/3/2", alu_a, alu_b, alu_ctrl);
    end
  endtask

  task automatic test_sub_backpressure();
    rx_q.delete();
    exp_q.delete();
    push_frame(3'b110, 32'd3, 32'd5);
    stream(10, 1'b1, 4, 1'b0, 300);
    checks++;
    if (rx_q.size() != 4) begin
      failures++;
      $display("FAIL sub_byte_count: got %0d bytes, required 4", rx_q.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (rx_q[i] !== exp_q[0][31-8*i -: 8]) begin
          failures++;
          $display("FAIL sub_byte[%0d]: got %02h required %02h", i, rx_q[i], exp_q[0][31-8*i -: 8]);
        end
      end
    end
    checks++;
    if (frame_count !== 16'd2) begin
      failures++;
      $display("FAIL sub_count: frame_count=%0d required 2", frame_count);
    end
  endtask

  task automatic test_bad_opcode();
    int start_cyc;
    int start_err;
    rx_q.delete();
    exp_q.delete();
    start_cyc = cyc;
    start_err = err_count;
    tx_q.push_back(8'h1A);
    push_frame(3'b010, 32'd1, 32'd1);
    stream(0, 1'b0, 4, 1'b0, 200);
    checks++;
    if (err_count - start_err != 1 || err_cyc != start_cyc + 1) begin
      failures++;
      $display("FAIL bad_opcode_err: pulses=%0d at edge %0d, required 1 at edge %0d",
               err_count - start_err, err_cyc, start_cyc + 1);
    end
    checks++;
    if (ctrl_at_err !== 3'b110) begin
      failures++;
      $display("FAIL bad_opcode_ctrl: alu_ctrl=%0d required 6 (unchanged)", ctrl_at_err);
    end
    checks++;
    if (rx_q.size() != 4 || {rx_q[0], rx_q[1], rx_q[2], rx_q[3]} !== exp_q[0]) begin
      failures++;
      $display("FAIL bad_opcode_result: got %0d bytes, required %08h", rx_q.size(), exp_q[0]);
    end
    checks++;
    if (frame_count !== 16'd3) begin
      failures++;
      $display("FAIL bad_opcode_count: frame_count=%0d required 3", frame_count);
    end
  endtask

  task automatic test_timeout();
    int start_err;
    bit ov_seen;
    rx_q.delete();
    exp_q.delete();
    start_err = err_count;
    ov_seen   = 1'b0;
    tx_q.push_back(8'h00);
    tx_q.push_back(8'hAA);
    tx_q.push_back(8'hBB);
    stream(0, 1'b0, 0, 1'b0, 50);
    for (int i = 0; i < 20; i++) begin
      cycle(1'b0, 8'h00, 1'b1);
      if (out_valid === 1'b1) ov_seen = 1'b1;
    end
    checks++;
    if (err_count - start_err != 1 || err_cyc - last_in_edge != TIMEOUT - 1) begin
      failures++;
      $display("FAIL timeout_err: pulses=%0d at idle edge %0d, required 1 at idle edge %0d",
               err_count - start_err, err_cyc - last_in_edge, TIMEOUT - 1);
    end
    checks++;
    if (busy !== 1'b0 || in_ready !== 1'b1 || ov_seen) begin
      failures++;
      $display("FAIL timeout_idle: busy=%b in_ready=%b output_seen=%b required 0/1/0",
               busy, in_ready, ov_seen);
    end
    // Previous A was 00000001; AA and BB shift in behind it.
    checks++;
    if (alu_a !== 32'h0001_AABB || alu_b !== 32'h0000_0001 || alu_ctrl !== 3'b000) begin
      failures++;
      $display("FAIL timeout_partial: a=%08h b=%08h ctrl=%0d required 0001aabb/00000001/0",
               alu_a, alu_b, alu_ctrl);
    end
    push_frame(3'b000, 32'h0000_FFFF, 32'h00FF_00FF);
    stream(0, 1'b0, 4, 1'b0, 200);
    checks++;
    if (rx_q.size() != 4 || {rx_q[0], rx_q[1], rx_q[2], rx_q[3]} !== 32'h0000_00FF) begin
      failures++;
      $display("FAIL timeout_next_frame: got %0d bytes, required 000000ff", rx_q.size());
    end
    checks++;
    if (frame_count !== 16'd4) begin
      failures++;
      $display("FAIL timeout_count: frame_count=%0d required 4", frame_count);
    end
  endtask

  task automatic test_reset_mid_send();
    bit ov_seen;
    rx_q.delete();
    exp_q.delete();
    ov_seen = 1'b0;
    push_frame(3'b001, 32'h1234_0000, 32'h0000_5678);
    stream(0, 1'b0, 2, 1'b0, 200);
    checks++;
    if (rx_q.size() != 2 || rx_q[0] !== 8'h12 || rx_q[1] !== 8'h34 || out_valid !== 1'b1) begin
      failures++;
      $display("FAIL mid_send_prefix: got %0d bytes out_valid=%b, required 12 34 with out_valid 1",
               rx_q.size(), out_valid);
    end
    reset = 1'b0;
    #1;
    checks++;
    if ({out_valid, busy, in_ready} !== 3'b000 || frame_count !== 16'd0) begin
      failures++;
      $display("FAIL mid_send_reset: out_valid/busy/in_ready=%b frame_count=%0d required 000/0",
               {out_valid, busy, in_ready}, frame_count);
    end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    cyc = 0;
    for (int i = 0; i < 6; i++) begin
      cycle(1'b0, 8'h00, 1'b1);
      if (out_valid === 1'b1) ov_seen = 1'b1;
    end
    checks++;
    if (ov_seen || busy !== 1'b0) begin
      failures++;
      $display("FAIL mid_send_resume: output_seen=%b busy=%b required 0/0", ov_seen, busy);
    end
    rx_q.delete();
    exp_q.delete();
    push_frame(3'b010, 32'hFFFF_FFFF, 32'h0000_0001);
    stream(0, 1'b0, 4, 1'b0, 200);
    checks++;
    if (rx_q.size() != 4 || {rx_q[0], rx_q[1], rx_q[2], rx_q[3]} !== exp_q[0]
        || frame_count !== 16'd1) begin
      failures++;
      $display("FAIL after_reset_frame: got %0d bytes frame_count=%0d, required %08h and 1",
               rx_q.size(), frame_count, exp_q[0]);
    end
  endtask

  task automatic test_back_to_back();
    logic [2:0]  ops[5];
    logic [31:0] got;
    ops[0] = 3'b000;
    ops[1] = 3'b001;
    ops[2] = 3'b010;
    ops[3] = 3'b110;
    ops[4] = 3'b111;
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    cyc        = 0;
    exec_edge  = -1;
    acc_count  = 0;
    iready_bad = 0;
    rx_q.delete();
    exp_q.delete();
    for (int f = 0; f < 300; f++) begin
      push_frame(ops[$urandom_range(0, 4)], pick_operand(), pick_operand());
    end
    stream(0, 1'b0, 1200, 1'b1, 6000);
    checks++;
    if (rx_q.size() != 1200) begin
      failures++;
      $display("FAIL b2b_byte_count: got %0d bytes, required 1200", rx_q.size());
    end else begin
      for (int f = 0; f < 300; f++) begin
        got = {rx_q[4*f], rx_q[4*f+1], rx_q[4*f+2], rx_q[4*f+3]};
        checks++;
        if (got !== exp_q[f]) begin
          failures++;
          $display("FAIL b2b_result[%0d]: got %08h required %08h", f, got, exp_q[f]);
        end
      end
    end
    checks++;
    if (frame_count !== 16'd300) begin
      failures++;
      $display("FAIL b2b_count: frame_count=%0d required 300", frame_count);
    end
    checks++;
    if (iready_bad != 0) begin
      failures++;
      $display("FAIL b2b_ready_in_send: in_ready high with out_valid on %0d cycles, required 0",
               iready_bad);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub_backpressure();
    test_bad_opcode();
    test_timeout();
    test_reset_mid_send();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
